// File: rtl/jtframe_resync_pkg.sv
// Shared types, limits and helpers for the video resync offset controller.
package jtframe_resync_pkg;

    // Lock state of the video timing tracker
    typedef enum logic {
        ST_UNLOCK = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    localparam int CNTW_DEF = 10;

    localparam logic signed [4:0] OFF_MIN = 5'b10000;   // -16
    localparam logic signed [4:0] OFF_MAX = 5'b01111;   // +15

    // One saturating step up or down; both or neither requested leaves the value alone
    function automatic logic signed [4:0] sat_step(input logic signed [4:0] v,
                                                   input logic              inc,
                                                   input logic              dec);
        sat_step = v;
        if (inc && !dec && (v != OFF_MAX)) begin
            sat_step = v + 5'sd1;
        end else if (dec && !inc && (v != OFF_MIN)) begin
            sat_step = v - 5'sd1;
        end
    endfunction

    // Move one unit toward the target; the target is always in range so no overflow
    function automatic logic signed [4:0] toward(input logic signed [4:0] cur,
                                                 input logic signed [4:0] tgt);
        toward = cur;
        if (cur < tgt) begin
            toward = cur + 5'sd1;
        end else if (cur > tgt) begin
            toward = cur - 5'sd1;
        end
    endfunction

endpackage

// File: rtl/jtframe_resync_frmcnt.sv
// Blanking edge detection, per-frame line counting and frame length comparison.
module jtframe_resync_frmcnt
    import jtframe_resync_pkg::*;
#(
    parameter int CNTW = CNTW_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pxl_cen_i,
    input  logic            lhbl_i,
    input  logic            lvbl_i,
    output logic            vb_edge_o,
    output logic            same_len_o,
    output logic [CNTW-1:0] lines_o
);

    logic            lhbl_q;
    logic            lvbl_q;
    logic [CNTW-1:0] cnt_q;
    logic [CNTW-1:0] lines_q;
    logic            hb_edge;
    logic [CNTW-1:0] len_now;

    // Rising edges of the active-low blanking signals, seen only on pixel enables
    always_comb begin
        hb_edge   = pxl_cen_i & lhbl_i & ~lhbl_q;
        vb_edge_o = pxl_cen_i & lvbl_i & ~lvbl_q;
        len_now   = cnt_q + CNTW'(1);
        // The frame that just ended is compared against the one before it
        same_len_o = vb_edge_o & (len_now == lines_q);
    end

    assign lines_o = lines_q;

    // Edge history, line counter and captured frame length
    always_ff @(posedge clk) begin
        if (rst) begin
            lhbl_q  <= 1'b1;
            lvbl_q  <= 1'b1;
            cnt_q   <= '0;
            lines_q <= '0;
        end else if (pxl_cen_i) begin
            lhbl_q <= lhbl_i;
            lvbl_q <= lvbl_i;
            if (vb_edge_o) begin
                cnt_q   <= '0;
                lines_q <= len_now;
            end else if (hb_edge) begin
                cnt_q <= cnt_q + CNTW'(1);
            end
        end
    end

endmodule

// File: rtl/jtframe_resync_ctrl.sv
// Resync offset controller: accepts OSD/joystick offset targets and ramps the
// applied offsets one step per frame while video timing is locked.
module jtframe_resync_ctrl
    import jtframe_resync_pkg::*;
#(
    parameter int CNTW        = CNTW_DEF,
    parameter int LOCK_FRAMES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pxl_cen,
    input  logic                   LHBL,
    input  logic                   LVBL,
    input  logic                   cfg_we,
    input  logic signed [4:0]      cfg_hoff,
    input  logic signed [4:0]      cfg_voff,
    input  logic                   adj_en,
    input  logic [3:0]             adj_dir,
    output logic signed [4:0]      hoffset,
    output logic signed [4:0]      voffset,
    output logic                   busy,
    output logic                   locked,
    output logic [CNTW-1:0]        lines
);

    state_t            state_q, state_d;
    logic [3:0]        stable_q, stable_d;
    logic signed [4:0] tgt_h_q, tgt_h_d;
    logic signed [4:0] tgt_v_q, tgt_v_d;
    logic signed [4:0] hoff_q, hoff_d;
    logic signed [4:0] voff_q, voff_d;
    logic              busy_q;
    logic              vb_edge;
    logic              same_len;

    jtframe_resync_frmcnt #(
        .CNTW (CNTW)
    ) u_frmcnt (
        .clk        (clk),
        .rst        (rst),
        .pxl_cen_i  (pxl_cen),
        .lhbl_i     (LHBL),
        .lvbl_i     (LVBL),
        .vb_edge_o  (vb_edge),
        .same_len_o (same_len),
        .lines_o    (lines)
    );

    // Target requests: a config write beats any joystick pulse in the same clk
    always_comb begin
        tgt_h_d = tgt_h_q;
        tgt_v_d = tgt_v_q;
        if (cfg_we) begin
            tgt_h_d = cfg_hoff;
            tgt_v_d = cfg_voff;
        end else if (adj_en) begin
            tgt_h_d = sat_step(tgt_h_q, adj_dir[0], adj_dir[1]);  // right / left
            tgt_v_d = sat_step(tgt_v_q, adj_dir[2], adj_dir[3]);  // down / up
        end
    end

    // Lock tracking and per-frame offset stepping, evaluated on each vertical edge
    always_comb begin
        state_d  = state_q;
        stable_d = stable_q;
        hoff_d   = hoff_q;
        voff_d   = voff_q;
        if (vb_edge) begin
            case (state_q)
                ST_UNLOCK: begin
                    if (same_len) begin
                        stable_d = stable_q + 4'd1;
                        if (stable_q == 4'(LOCK_FRAMES - 1)) begin
                            state_d = ST_LOCKED;
                        end
                    end else begin
                        stable_d = 4'd0;
                    end
                end
                ST_LOCKED: begin
                    hoff_d = toward(hoff_q, tgt_h_q);
                    voff_d = toward(voff_q, tgt_v_q);
                    if (!same_len) begin
                        stable_d = 4'd0;
                        state_d  = ST_UNLOCK;
                    end
                end
                default: state_d = ST_UNLOCK;
            endcase
        end
    end

    // State, target and applied offset registers; busy lags the offsets by one clk
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_UNLOCK;
            stable_q <= 4'd0;
            tgt_h_q  <= 5'sd0;
            tgt_v_q  <= 5'sd0;
            hoff_q   <= 5'sd0;
            voff_q   <= 5'sd0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            stable_q <= stable_d;
            tgt_h_q  <= tgt_h_d;
            tgt_v_q  <= tgt_v_d;
            hoff_q   <= hoff_d;
            voff_q   <= voff_d;
            busy_q   <= (hoff_q != tgt_h_q) | (voff_q != tgt_v_q);
        end
    end

    assign hoffset = hoff_q;
    assign voffset = voff_q;
    assign busy    = busy_q;
    assign locked  = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_jtframe_resync_ctrl.sv
// Bench for jtframe_resync_ctrl: frame-level video stimulus with a behavioural model.
module tb_jtframe_resync_ctrl;

    localparam int CNTW  = 10;
    localparam int LOCKF = 4;
    localparam int V_BLK = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   pxl_cen;
    logic                   LHBL;
    logic                   LVBL;
    logic                   cfg_we;
    logic signed [4:0]      cfg_hoff;
    logic signed [4:0]      cfg_voff;
    logic                   adj_en;
    logic [3:0]             adj_dir;
    logic signed [4:0]      hoffset;
    logic signed [4:0]      voffset;
    logic                   busy;
    logic                   locked;
    logic [CNTW-1:0]        lines;

    int total = 0;
    int bad   = 0;

    // Model state
    int m_th, m_tv, m_ho, m_vo, m_stable, m_last, m_prev;
    bit m_lock, m_first;

    always #5 clk = ~clk;

    jtframe_resync_ctrl #(
        .CNTW        (CNTW),
        .LOCK_FRAMES (LOCKF)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .pxl_cen  (pxl_cen),
        .LHBL     (LHBL),
        .LVBL     (LVBL),
        .cfg_we   (cfg_we),
        .cfg_hoff (cfg_hoff),
        .cfg_voff (cfg_voff),
        .adj_en   (adj_en),
        .adj_dir  (adj_dir),
        .hoffset  (hoffset),
        .voffset  (voffset),
        .busy     (busy),
        .locked   (locked),
        .lines    (lines)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int clamp(input int v);
        return (v > 15) ? 15 : ((v < -16) ? -16 : v);
    endfunction

    task automatic model_reset();
        m_th = 0; m_tv = 0; m_ho = 0; m_vo = 0;
        m_stable = 0; m_last = 0; m_prev = 0;
        m_lock = 0; m_first = 1;
    endtask

    task automatic model_req(input bit we, input int h, input int v, input bit en, input logic [3:0] dir);
        if (we) begin
            m_th = h;
            m_tv = v;
        end else if (en) begin
            if (dir[0] && !dir[1]) m_th = clamp(m_th + 1);
            if (dir[1] && !dir[0]) m_th = clamp(m_th - 1);
            if (dir[2] && !dir[3]) m_tv = clamp(m_tv + 1);
            if (dir[3] && !dir[2]) m_tv = clamp(m_tv - 1);
        end
    endtask

    // One vertical edge: frame length is the previous call's line count (unknown after reset)
    task automatic model_edge(input int n_this);
        int  len;
        bit  same;
        len  = m_first ? -1 : m_prev;
        same = (len == m_last);
        if (m_lock) begin
            if (m_ho < m_th) m_ho++; else if (m_ho > m_th) m_ho--;
            if (m_vo < m_tv) m_vo++; else if (m_vo > m_tv) m_vo--;
            if (!same) begin
                m_lock   = 0;
                m_stable = 0;
            end
        end else if (same) begin
            m_stable++;
            if (m_stable == LOCKF) m_lock = 1;
        end else begin
            m_stable = 0;
        end
        m_last  = len;
        m_prev  = n_this;
        m_first = 0;
    endtask

    task automatic req(input bit we, input int h, input int v, input bit en, input logic [3:0] dir);
        @(negedge clk);
        cfg_we = we; cfg_hoff = 5'(h); cfg_voff = 5'(v); adj_en = en; adj_dir = dir;
        model_req(we, h, v, en, dir);
        @(negedge clk);
        cfg_we = 1'b0; adj_dir = 4'd0;
    endtask

    // n lines of 2 pixels (blank, active), pxl_cen one clk in four; LVBL rises with LHBL on line V_BLK
    task automatic run_frame(input int n, input bit rnd);
        for (int ln = 0; ln < n; ln++) begin
            for (int px = 0; px < 2; px++) begin
                @(negedge clk);
                LHBL    = (px == 1);
                LVBL    = (ln > V_BLK) || (ln == V_BLK && px == 1);
                pxl_cen = 1'b1;
                @(negedge clk);
                pxl_cen = 1'b0;
                if (rnd && ln < V_BLK && px == 0) begin
                    cfg_we   = ($urandom_range(0, 7) == 0);
                    cfg_hoff = 5'($urandom_range(0, 31));
                    cfg_voff = 5'($urandom_range(0, 31));
                    adj_en   = ($urandom_range(0, 3) != 0);
                    adj_dir  = 4'($urandom_range(0, 15));
                    model_req(cfg_we, int'(cfg_hoff), int'(cfg_voff), adj_en, adj_dir);
                end
                @(negedge clk);
                cfg_we  = 1'b0;
                adj_dir = 4'd0;
                @(negedge clk);
            end
        end
        model_edge(n);
    endtask

    task automatic check_frame(input string tag);
        chk({tag, "_locked"}, locked, m_lock);
        chk({tag, "_hoff"}, hoffset, m_ho);
        chk({tag, "_voff"}, voffset, m_vo);
        chk({tag, "_busy"}, busy, (m_ho != m_th) || (m_vo != m_tv));
        if (m_last >= 0) chk({tag, "_lines"}, lines, m_last);
    endtask

    // Reset with competing requests and pxl_cen in the same clk
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; cfg_we = 1'b1; cfg_hoff = 5'sd7; cfg_voff = -5'sd3;
        adj_en = 1'b1; adj_dir = 4'b0101; pxl_cen = 1'b1;
        @(negedge clk);
        rst = 1'b0; cfg_we = 1'b0; adj_dir = 4'd0; pxl_cen = 1'b0;
        model_reset();
        chk("rst_hoff", hoffset, 0);
        chk("rst_voff", voffset, 0);
        chk("rst_busy", busy, 0);
        chk("rst_locked", locked, 0);
        chk("rst_lines", lines, 0);
        chk("rst_tgt_h", dut.tgt_h_q, 0);
        chk("rst_tgt_v", dut.tgt_v_q, 0);
    endtask

    initial begin
        rst = 1'b1; pxl_cen = 1'b0; LHBL = 1'b1; LVBL = 1'b1;
        cfg_we = 1'b0; cfg_hoff = '0; cfg_voff = '0; adj_en = 1'b0; adj_dir = '0;
        model_reset();
        repeat (3) @(negedge clk);
        do_reset();

        // Lock acquisition on 262-line frames
        for (int i = 0; i < 6; i++) begin
            run_frame(262, 1'b0);
            check_frame("acq");
        end
        chk("lock_6th_edge", locked, 1);
        chk("lines_262", lines, 262);

        // Arbitration and cancellation
        req(1'b1, 5, 0, 1'b1, 4'b0001);
        chk("cfg_wins", dut.tgt_h_q, 5);
        req(1'b0, 0, 0, 1'b1, 4'b0011);
        chk("lr_cancel", dut.tgt_h_q, 5);
        req(1'b0, 0, 0, 1'b1, 4'b1100);
        chk("ud_cancel", dut.tgt_v_q, 0);
        req(1'b0, 0, 0, 1'b0, 4'b0010);
        chk("adj_dis", dut.tgt_h_q, 5);

        // Saturation on repeated right pulses
        req(1'b1, 10, 0, 1'b0, 4'd0);
        for (int i = 0; i < 20; i++) begin
            req(1'b0, 0, 0, 1'b1, 4'b0001);
            chk("sat_step", dut.tgt_h_q, m_th);
        end
        chk("sat_15", dut.tgt_h_q, 15);
        for (int i = 0; i < 20; i++) req(1'b0, 0, 0, 1'b1, 4'b1000);
        chk("sat_m16", dut.tgt_v_q, -16);

        // Ramp to (+3,-2)
        req(1'b1, 3, -2, 1'b0, 4'd0);
        @(negedge clk);
        chk("ramp_busy", busy, 1);
        for (int i = 1; i <= 3; i++) begin
            run_frame(262, 1'b0);
            check_frame("ramp");
            chk("ramp_h_step", hoffset, i);
            chk("ramp_v_step", voffset, (i < 2) ? -i : -2);
        end

        // Random requests while locked
        for (int i = 0; i < 4; i++) begin
            run_frame(262, 1'b1);
            check_frame("rand");
        end

        // Frame length glitch mid-ramp, relock, resume
        req(1'b1, -5, 4, 1'b0, 4'd0);
        run_frame(262, 1'b0); check_frame("gl_a");
        run_frame(263, 1'b0); check_frame("gl_b");
        run_frame(262, 1'b0); check_frame("gl_c");
        chk("gl_unlock", locked, 0);
        for (int i = 0; i < 6; i++) begin
            run_frame(262, 1'b0);
            check_frame("gl_re");
        end
        chk("gl_relock", locked, 1);

        // Reset mid-ramp
        req(1'b1, 15, -16, 1'b0, 4'd0);
        run_frame(262, 1'b0);
        check_frame("pre_rst");
        chk("pre_rst_busy", busy, 1);
        do_reset();
        for (int i = 0; i < 2; i++) begin
            run_frame(262, 1'b0);
            check_frame("post_rst");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
